// File: rtl/bus_rr_scheduler.sv
// Round-robin request/grant scheduler for the serial ADS bus with slave-select decode.
// Define BUS_SCHED_PRIO_EN to replace round-robin with fixed lowest-index priority.
//
// state    | meaning
// IDLE     | bus free, arbitrate among requesters
// GRANT    | master granted, waiting for first address bit
// ADDR     | shifting in slave-select address bits
// SLV_WAIT | selected slave busy, grant held
// CONNECT  | master routed to slave until request drops
// RELEASE  | one-cycle bus turnaround
module bus_rr_scheduler #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 3,
    parameter int SEL_BITS    = 2,
    parameter int MIDX_W      = 1,
    parameter int TIMEOUT     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] m_request,
    input  logic [NUM_MASTERS-1:0] m_address_valid,
    input  logic [NUM_MASTERS-1:0] m_address,
    input  logic [NUM_SLAVES-1:0]  s_busy,
    output logic [NUM_MASTERS-1:0] m_grant,
    output logic [MIDX_W-1:0]      grant_idx,
    output logic [NUM_SLAVES-1:0]  slave_sel,
    output logic                   timeout_err,
    output logic                   decode_err,
    output logic [2:0]             state
);

    localparam int CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int BCNT_W = $clog2(SEL_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GRANT    = 3'd1,
        S_ADDR     = 3'd2,
        S_SLV_WAIT = 3'd3,
        S_CONNECT  = 3'd4,
        S_RELEASE  = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [MIDX_W-1:0]      gidx_q, gidx_d;
    logic [MIDX_W-1:0]      last_q, last_d;
    logic [NUM_SLAVES-1:0]  sel_q, sel_d;
    logic                   tout_q, tout_d;
    logic                   derr_q, derr_d;
    logic [SEL_BITS-1:0]    shift_q, shift_d;
    logic [BCNT_W-1:0]      bcnt_q, bcnt_d;
    logic [CNT_W-1:0]       tcnt_q, tcnt_d;

    logic [NUM_MASTERS-1:0] req_sh, valid_sh, addr_sh;
    logic                   req_g, valid_g, addr_g;
    logic [NUM_SLAVES-1:0]  sel_oh;
    logic                   sel_ok, busy_hit;
    logic                   pick_ok;
    logic [MIDX_W-1:0]      pick_idx;

    // Signals of the currently granted master; other masters are never looked at.
    always_comb begin
        req_sh   = m_request >> gidx_q;
        valid_sh = m_address_valid >> gidx_q;
        addr_sh  = m_address >> gidx_q;
        req_g    = req_sh[0];
        valid_g  = valid_sh[0];
        addr_g   = addr_sh[0];
    end

    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel_oh[i] = (shift_q == SEL_BITS'(i));
        end
        sel_ok   = int'(shift_q) < NUM_SLAVES;
        busy_hit = |(s_busy & sel_oh);
    end

    // Circular scan starting one past the base index.
    always_comb begin
        int                     base;
        int                     cand;
        logic [NUM_MASTERS-1:0] rot;
        pick_ok  = 1'b0;
        pick_idx = '0;
        cand     = 0;
        rot      = '0;
`ifdef BUS_SCHED_PRIO_EN
        base = NUM_MASTERS - 1;
`else
        base = int'(last_q);
`endif
        for (int off = 1; off <= NUM_MASTERS; off++) begin
            cand = (base + off) % NUM_MASTERS;
            rot  = m_request >> cand;
            if (!pick_ok && rot[0]) begin
                pick_ok  = 1'b1;
                pick_idx = MIDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        sel_d   = sel_q;
        tout_d  = 1'b0;
        derr_d  = 1'b0;
        shift_d = shift_q;
        bcnt_d  = bcnt_q;
        tcnt_d  = tcnt_q;

        case (state_q)
            S_IDLE: begin
                if (pick_ok) begin
                    state_d = S_GRANT;
                    grant_d = NUM_MASTERS'(1) << pick_idx;
                    gidx_d  = pick_idx;
                    tcnt_d  = CNT_W'(TIMEOUT - 1);
                    bcnt_d  = '0;
                    shift_d = '0;
                end
            end
            S_GRANT: begin
                if (!req_g) begin
                    state_d = S_RELEASE;
                end else if (valid_g) begin
                    state_d = S_ADDR;
                    shift_d = SEL_BITS'(addr_g);
                    bcnt_d  = BCNT_W'(1);
                end else if (tcnt_q == '0) begin
                    state_d = S_RELEASE;
                    tout_d  = 1'b1;
                end else begin
                    tcnt_d = tcnt_q - CNT_W'(1);
                end
            end
            S_ADDR: begin
                if (!req_g) begin
                    state_d = S_RELEASE;
                end else if (bcnt_q == BCNT_W'(SEL_BITS)) begin
                    if (!sel_ok) begin
                        state_d = S_RELEASE;
                        derr_d  = 1'b1;
                    end else if (busy_hit) begin
                        state_d = S_SLV_WAIT;
                        tcnt_d  = CNT_W'(TIMEOUT - 1);
                    end else begin
                        state_d = S_CONNECT;
                        sel_d   = sel_oh;
                    end
                end else if (valid_g) begin
                    shift_d = (shift_q << 1) | SEL_BITS'(addr_g);
                    bcnt_d  = bcnt_q + BCNT_W'(1);
                end
            end
            S_SLV_WAIT: begin
                if (!req_g) begin
                    state_d = S_RELEASE;
                end else if (!busy_hit) begin
                    state_d = S_CONNECT;
                    sel_d   = sel_oh;
                end else if (tcnt_q == '0) begin
                    state_d = S_RELEASE;
                    tout_d  = 1'b1;
                end else begin
                    tcnt_d = tcnt_q - CNT_W'(1);
                end
            end
            S_CONNECT: begin
                if (!req_g) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
                last_d  = gidx_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_RELEASE || state_d == S_IDLE) begin
            grant_d = '0;
            sel_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= MIDX_W'(NUM_MASTERS - 1);
            sel_q   <= '0;
            tout_q  <= 1'b0;
            derr_q  <= 1'b0;
            shift_q <= '0;
            bcnt_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            tout_q  <= tout_d;
            derr_q  <= derr_d;
            shift_q <= shift_d;
            bcnt_q  <= bcnt_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign m_grant     = grant_q;
    assign grant_idx   = gidx_q;
    assign slave_sel   = sel_q;
    assign timeout_err = tout_q;
    assign decode_err  = derr_q;
    assign state       = state_q;

endmodule
